// File: rtl/uk_light_monitor.sv
// uk_light_monitor: passive watchdog for the UK traffic-light lamp interface; tracks the phase,
// flags multi-lamp, sequence and duration faults, and counts completed light cycles.
module uk_light_monitor #(
  parameter int unsigned RED_CYC    = 51,
  parameter int unsigned RDYLW_CYC  = 11,
  parameter int unsigned GREEN_CYC  = 31,
  parameter int unsigned YELLOW_CYC = 11,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        red,
  input  logic        ylwred,
  input  logic        green,
  input  logic        yellow,
  input  logic        clear_err,
  output logic [2:0]  phase_out,
  output logic        err_multi,
  output logic        err_seq,
  output logic        err_timing,
  output logic        err_sticky,
  output logic [15:0] cycle_count
);
  typedef enum logic [2:0] {IDLE, RED, RDYLW, GREEN, YELLOW, SYNC} ph_t;
  ph_t              phase_q, phase_d, cur, nxt;
  logic [CNT_W-1:0] dur_q, dur_d, expd;
  logic             ovr_q, ovr_d, prev_red_q;
  logic             multi_q, multi_d, seq_q, seq_d, tim_q, tim_d, sticky_q;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       lit;
  logic             any, multi;
  assign lit   = {red, ylwred, green, yellow};
  assign any   = |lit;
  assign multi = any && !$onehot(lit);
  assign cur   = red ? RED : ylwred ? RDYLW : green ? GREEN : yellow ? YELLOW : IDLE;
  assign nxt   = phase_q == YELLOW ? RED : ph_t'(phase_q + 3'd1);
  assign expd  = phase_q == RED   ? CNT_W'(RED_CYC)   : phase_q == RDYLW  ? CNT_W'(RDYLW_CYC) :
                 phase_q == GREEN ? CNT_W'(GREEN_CYC) : CNT_W'(YELLOW_CYC);
  always_comb begin
    phase_d = phase_q;
    dur_d   = dur_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    multi_d = 1'b0;
    seq_d   = 1'b0;
    tim_d   = 1'b0;
    if (multi) begin
      multi_d = 1'b1;
      phase_d = SYNC;
      dur_d   = '0;
      ovr_d   = 1'b0;
    end else if (!enable) begin
      seq_d   = any && phase_q != SYNC;
      phase_d = any ? SYNC : IDLE;
      dur_d   = '0;
      ovr_d   = 1'b0;
    end else if (phase_q == IDLE || phase_q == SYNC) begin
      // SYNC only re-locks on a fresh red onset, never mid-red
      if (cur == RED && (phase_q == IDLE || !prev_red_q)) begin
        phase_d = RED;
        dur_d   = CNT_W'(1);
        ovr_d   = 1'b0;
      end else if (phase_q == IDLE && any) begin
        seq_d   = 1'b1;
        phase_d = SYNC;
      end
    end else if (cur == phase_q) begin
      tim_d = dur_q >= expd && !ovr_q;
      ovr_d = ovr_q || dur_q >= expd;
      dur_d = &dur_q ? dur_q : dur_q + CNT_W'(1);
    end else if (cur == nxt) begin
      tim_d   = dur_q < expd;
      phase_d = nxt;
      dur_d   = CNT_W'(1);
      ovr_d   = 1'b0;
      cnt_d   = phase_q == YELLOW && !(&cnt_q) ? cnt_q + 16'd1 : cnt_q;
    end else begin
      seq_d   = 1'b1;
      phase_d = SYNC;
      dur_d   = '0;
      ovr_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= IDLE;
      dur_q      <= '0;
      ovr_q      <= 1'b0;
      prev_red_q <= 1'b0;
      multi_q    <= 1'b0;
      seq_q      <= 1'b0;
      tim_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      dur_q      <= dur_d;
      ovr_q      <= ovr_d;
      prev_red_q <= !multi && cur == RED;
      multi_q    <= multi_d;
      seq_q      <= seq_d;
      tim_q      <= tim_d;
      sticky_q   <= (sticky_q && !clear_err) || multi_d || seq_d || tim_d;
      cnt_q      <= cnt_d;
    end
  end
  assign phase_out   = phase_q;
  assign err_multi   = multi_q;
  assign err_seq     = seq_q;
  assign err_timing  = tim_q;
  assign err_sticky  = sticky_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_uk_light_monitor.sv
// tb_uk_light_monitor: directed and random lamp sequences scored against a behavioural model.
module tb_uk_light_monitor;
  logic clk = 0, rst_n = 0, enable = 0, red = 0, ylwred = 0, green = 0, yellow = 0, clear_err = 0;
  logic [2:0]  phase_out;
  logic        err_multi, err_seq, err_timing, err_sticky;
  logic [15:0] cycle_count;
  uk_light_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .red(red), .ylwred(ylwred), .green(green),
    .yellow(yellow), .clear_err(clear_err), .phase_out(phase_out), .err_multi(err_multi),
    .err_seq(err_seq), .err_timing(err_timing), .err_sticky(err_sticky), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0]  ph;
    logic        m, s, t, st;
    logic [15:0] cnt;
  } obs_t;
  obs_t q[$];
  int checks = 0, errors = 0;
  int exp_len[5] = '{0, 51, 11, 31, 11};
  // model state: phase number, unbounded time in phase, previous sample was a lone red
  int m_ph = 0, m_dur = 0, m_cnt = 0;
  bit m_prev_red = 0, m_st = 0;
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = '{phase_out, err_multi, err_seq, err_timing, err_sticky, cycle_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got ph=%0d m=%b s=%b t=%b st=%b cnt=%0d want ph=%0d m=%b s=%b t=%b st=%b cnt=%0d",
                 $time, a.ph, a.m, a.s, a.t, a.st, a.cnt, e.ph, e.m, e.s, e.t, e.st, e.cnt);
      end
    end
  end
  function automatic obs_t model(bit en, logic [3:0] v, bit clr);
    int n, code;
    bit m, s, t;
    n = $countones(v);
    code = n == 1 ? (v[3] ? 1 : v[2] ? 2 : v[1] ? 3 : 4) : 0;
    m = 0; s = 0; t = 0;
    if (n > 1) begin m = 1; m_ph = 5; m_dur = 0; end
    else if (!en) begin s = n > 0 && m_ph != 5; m_ph = n > 0 ? 5 : 0; m_dur = 0; end
    else if (m_ph == 0) begin
      if (code == 1) begin m_ph = 1; m_dur = 1; end
      else if (code != 0) begin s = 1; m_ph = 5; end
    end else if (m_ph == 5) begin
      if (code == 1 && !m_prev_red) begin m_ph = 1; m_dur = 1; end
    end else if (code == m_ph) begin
      t = m_dur == exp_len[m_ph];
      m_dur++;
    end else if (code != 0 && code == m_ph % 4 + 1) begin
      t = m_dur < exp_len[m_ph];
      if (m_ph == 4 && m_cnt < 65535) m_cnt++;
      m_ph = code; m_dur = 1;
    end else begin s = 1; m_ph = 5; m_dur = 0; end
    m_prev_red = code == 1;
    m_st = (m_st && !clr) || m || s || t;
    return '{3'(m_ph), m, s, t, m_st, 16'(m_cnt)};
  endfunction
  task automatic drive(bit en, logic [3:0] v, bit clr);
    @(negedge clk);
    rst_n = 1; enable = en; {red, ylwred, green, yellow} = v; clear_err = clr;
    q.push_back(model(en, v, clr));
  endtask
  function automatic logic [3:0] lamps(int code);
    logic [3:0] v;
    if (code == 5) begin
      do v = 4'($urandom_range(0, 15)); while ($countones(v) < 2);
    end else v = code == 0 ? 4'b0 : 4'b1000 >> (code - 1);
    return v;
  endfunction
  task automatic seg(bit en, int code, int len);
    for (int i = 0; i < len; i++) drive(en, lamps(code), 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({phase_out, err_multi, err_seq, err_timing, err_sticky, cycle_count} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset got ph=%0d m=%b s=%b t=%b st=%b cnt=%0d want all zero",
               phase_out, err_multi, err_seq, err_timing, err_sticky, cycle_count);
    end
    m_ph = 0; m_dur = 0; m_cnt = 0; m_prev_red = 0; m_st = 0;
    q.push_back('0);
  endtask
  initial begin
    int sl = 1, wait_cyc = 0;
    repeat (2) @(negedge clk);
    do_reset();
    drive(1, 4'b0, 1);
    seg(1, 1, 51); seg(1, 2, 11); seg(1, 3, 31); seg(1, 4, 11); seg(1, 1, 51);
    seg(1, 2, 11); seg(1, 3, 30); seg(1, 4, 11); seg(1, 1, 60);
    seg(1, 5, 1); seg(1, 0, 1); seg(1, 1, 51); seg(1, 3, 1);
    drive(1, 4'b0, 1); seg(1, 0, 2);
    seg(1, 1, 51); seg(1, 2, 11); seg(1, 3, 10); seg(0, 0, 3);
    seg(1, 0, 1); seg(1, 1, 20);
    do_reset();
    seg(1, 1, 300); seg(1, 2, 11);
    seg(0, 4, 2); seg(0, 0, 1); seg(1, 4, 1); seg(1, 1, 3); seg(1, 0, 1); seg(1, 1, 5);
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        int len;
        sl = sl % 4 + 1;
        len = exp_len[sl] + $urandom_range(0, 4) - 2;
        for (int i = 0; i < len; i++) drive(1, lamps(sl), $urandom_range(0, 31) == 0);
      end else begin
        int code = $urandom_range(0, 5);
        bit en = $urandom_range(0, 3) != 0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) drive(en, lamps(code), $urandom_range(0, 15) == 0);
      end
    end
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
